// File: rtl/seq_det_param.sv
// seq_det_param -- parametrised serial sequence detector.
//
// Compares a sliding window of the serial input against a runtime-loadable
// pattern of 1..MAX_LEN bits. Overlapping and non-overlapping match modes
// are supported.
//
// Optional feature macro: SEQ_DET_CNT_EN
//   When defined, this adds the o_hit_cnt port and a saturating hit counter.
//   The counter is cleared by reset and by i_cfg_we.
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   i_bit_vld   in   qualifier for i_seq_bit; a bit is consumed only when high
//   i_seq_bit   in   serial data bit
//   i_cfg_we    in   single-cycle load of i_cfg_pat/i_cfg_len/i_cfg_ovl
//   i_cfg_pat   in   pattern; bit[len-1] is received first, bit[0] last
//   i_cfg_len   in   pattern length; 0 or >MAX_LEN is clamped to MAX_LEN
//   i_cfg_ovl   in   1 = overlapping matches, 0 = non-overlapping
//   o_hit       out  registered one-cycle pulse per match
//   o_fill      out  valid history bits held, saturating at len
//   o_state     out  00 IDLE, 01 FILL, 10 ARMED
//   o_hit_cnt   out  saturating match count (SEQ_DET_CNT_EN only)
module seq_det_param #(
  parameter int unsigned        MAX_LEN = 8,
  parameter int unsigned        LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned        CNT_W   = 16,
  parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(8'h16),
  parameter int unsigned        RST_LEN = 5,
  parameter logic               RST_OVL = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_bit_vld,
  input  logic               i_seq_bit,
  input  logic               i_cfg_we,
  input  logic [MAX_LEN-1:0] i_cfg_pat,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_cfg_ovl,
  output logic               o_hit,
  output logic [LEN_W-1:0]   o_fill,
  output logic [1:0]         o_state
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0]   o_hit_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_ARMED = 2'b10
  } state_t;

  // Configuration registers
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;

  // Only MAX_LEN-1 history bits are stored: the comparison window is this
  // history plus the bit arriving this cycle.
  logic [MAX_LEN-2:0] r_sh;
  logic [LEN_W-1:0]   r_fill;
  logic               r_hit;
  state_t             r_state;
`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0]   r_cnt;
`endif

  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_n;
  logic [LEN_W-1:0]   w_cfg_len;
  logic               w_match;

  // Map a fill level onto the reported state.
  function automatic state_t decode_state(input logic [LEN_W-1:0] fill,
                                          input logic [LEN_W-1:0] len);
    if (fill == {LEN_W{1'b0}}) begin
      return ST_IDLE;
    end else if (fill < len) begin
      return ST_FILL;
    end else begin
      return ST_ARMED;
    end
  endfunction

  // Window, length mask, next fill level, match detect and config clamp
  always_comb begin
    w_window = {r_sh, i_seq_bit};
    w_mask   = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
    w_fill_n  = (r_fill >= r_len) ? r_len : (r_fill + LEN_W'(1));
    // Pattern bits above len are masked off and never take part in a match.
    w_match   = (w_fill_n == r_len) &&
                (((w_window ^ r_pat) & w_mask) == {MAX_LEN{1'b0}});
    w_cfg_len = ((i_cfg_len == {LEN_W{1'b0}}) || (i_cfg_len > LEN_W'(MAX_LEN)))
                ? LEN_W'(MAX_LEN) : i_cfg_len;
  end

  // Detector FSM: config load, shift/match, fill tracking and hit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat   <= RST_PAT;
      r_len   <= LEN_W'(RST_LEN);
      r_ovl   <= RST_OVL;
      r_sh    <= {(MAX_LEN-1){1'b0}};
      r_fill  <= {LEN_W{1'b0}};
      r_hit   <= 1'b0;
      r_state <= ST_IDLE;
`ifdef SEQ_DET_CNT_EN
      r_cnt   <= {CNT_W{1'b0}};
`endif
    end else if (i_cfg_we) begin
      // A configuration load wins over a bit offered in the same cycle.
      r_pat   <= i_cfg_pat;
      r_len   <= w_cfg_len;
      r_ovl   <= i_cfg_ovl;
      r_sh    <= {(MAX_LEN-1){1'b0}};
      r_fill  <= {LEN_W{1'b0}};
      r_hit   <= 1'b0;
      r_state <= ST_IDLE;
`ifdef SEQ_DET_CNT_EN
      r_cnt   <= {CNT_W{1'b0}};
`endif
    end else if (i_bit_vld) begin
      r_hit <= w_match;
      if (w_match && !r_ovl) begin
        // Non-overlap: discard history so the next match needs len fresh bits.
        r_sh    <= {(MAX_LEN-1){1'b0}};
        r_fill  <= {LEN_W{1'b0}};
        r_state <= ST_IDLE;
      end else begin
        r_sh    <= w_window[MAX_LEN-2:0];
        r_fill  <= w_fill_n;
        r_state <= decode_state(w_fill_n, r_len);
      end
`ifdef SEQ_DET_CNT_EN
      if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
`endif
    end else begin
      r_hit <= 1'b0;
    end
  end

  assign o_hit     = r_hit;
  assign o_fill    = r_fill;
  assign o_state   = r_state;
`ifdef SEQ_DET_CNT_EN
  assign o_hit_cnt = r_cnt;
`endif

endmodule
